otter_intc_csr: RTL and testbench

Parametrised machine-mode CSR file and multi-source interrupt controller for the OTTER multicycle core. It replaces the single `CPU_INTR` pin and the tied-off `csr_RD`/`MTVEC`/`MEPC`/`mret_exec` paths with `NUM_IRQ` synchronised interrupt channels. Each channel has a per-channel edge or level mode, a fixed priority and an enable bit. The block sits beside `CU_FSM`: it raises `int_req`, receives `int_taken`/`mret_exec`, and supplies `csr_rd`, `trap_vec` and `mepc` to the RF and PC muxes.

---
 rtl/otter_csr_pkg.sv | 40 ++++
 rtl/irq_sync_edge.sv | 33 +++
 rtl/otter_intc_csr.sv | 166 ++++++++++++++++
 tb/tb_otter_intc_csr.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_csr_pkg.sv
// Shared constants and types for the OTTER machine-mode CSR file and interrupt controller.
package otter_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam int unsigned MIE_BIT        = 3;
   localparam int unsigned MPIE_BIT       = 7;
   localparam int unsigned LOCAL_IRQ_BASE = 16;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_t;

   typedef enum logic {
      MTVEC_DIRECT   = 1'b0,
      MTVEC_VECTORED = 1'b1
   } mtvec_mode_t;

   // Read-modify-write result of a Zicsr operation
   function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old_v, logic [31:0] wd);
      logic [31:0] res;
      res = old_v;
      case (op)
         CSR_OP_RW: res = wd;
         CSR_OP_RS: res = old_v | wd;
         CSR_OP_RC: res = old_v & ~wd;
         default:   res = old_v;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-channel synchroniser for an asynchronous interrupt line with a rising-edge detector.
module irq_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq_i,
   output logic level,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q, dly_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
      dly_d  = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign level  = sync_q[SYNC_STAGES-1];
   assign rise_c = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/otter_intc_csr.sv
// Machine-mode CSR file and fixed-priority multi-source interrupt controller for the OTTER core.
module otter_intc_csr
   import otter_csr_pkg::*;
#(
   parameter int unsigned        NUM_IRQ     = 4,
   parameter int unsigned        SYNC_STAGES = 2,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [11:0]        csr_addr,
   input  logic [31:0]        csr_wd,
   input  logic [1:0]         csr_op,
   input  logic               csr_we,
   input  logic [31:0]        pc,
   input  logic               int_taken,
   input  logic               mret_exec,
   output logic [31:0]        csr_rd,
   output logic               int_req,
   output logic [31:0]        trap_vec,
   output logic [31:0]        mepc
);

   localparam int unsigned ID_W    = 4;
   localparam int unsigned CAUSE_W = 5;

   logic [NUM_IRQ-1:0] sync_lvl, rise_c;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] pending_c, active_c;
   logic [ID_W-1:0]    id_c;
   logic [CAUSE_W-1:0] cause_c;
   logic               take_c, mret_c, wr_c;
   logic [31:0]        rd_c, new_c;

   logic               mstat_mie_q, mstat_mie_d;
   logic               mstat_mpie_q, mstat_mpie_d;
   logic [NUM_IRQ-1:0] mie_en_q, mie_en_d;
   logic [29:0]        mtvec_base_q, mtvec_base_d;
   mtvec_mode_t        mtvec_mode_q, mtvec_mode_d;
   logic [29:0]        mepc_q, mepc_d;
   logic [31:0]        mcause_q, mcause_d;

   logic               unused_ok;
   assign unused_ok = ^pc[1:0];

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk    (clk),
         .rst_n  (rst_n),
         .irq_i  (irq_i[g]),
         .level  (sync_lvl[g]),
         .rise_c (rise_c[g])
      );
   end

   // Pending view and lowest-index-wins arbitration
   always_comb begin
      for (int i = 0; i < NUM_IRQ; i++) begin
         pending_c[i] = EDGE_MASK[i] ? pend_q[i] : sync_lvl[i];
      end
      active_c = pending_c & mie_en_q;
      id_c     = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active_c[i]) id_c = ID_W'(i);
      end
      cause_c = CAUSE_W'(LOCAL_IRQ_BASE) + {1'b0, id_c};
   end

   assign int_req = mstat_mie_q & (|active_c);
   assign take_c  = int_taken & int_req;
   assign mret_c  = mret_exec & ~take_c;
   assign wr_c    = csr_we & (csr_op != 2'b00) & ~take_c & ~mret_exec;

   always_comb begin
      rd_c = '0;
      case (csr_addr)
         CSR_MSTATUS: begin
            rd_c[MIE_BIT]  = mstat_mie_q;
            rd_c[MPIE_BIT] = mstat_mpie_q;
         end
         CSR_MIE:     rd_c[LOCAL_IRQ_BASE +: NUM_IRQ] = mie_en_q;
         CSR_MTVEC:   rd_c = {mtvec_base_q, 1'b0, mtvec_mode_q};
         CSR_MEPC:    rd_c = {mepc_q, 2'b00};
         CSR_MCAUSE:  rd_c = mcause_q;
         CSR_MIP:     rd_c[LOCAL_IRQ_BASE +: NUM_IRQ] = pending_c;
         default:     rd_c = '0;
      endcase
      new_c = csr_apply(csr_op_t'(csr_op), rd_c, csr_wd);
   end

   // Trap entry beats MRET beats software writes
   always_comb begin
      mstat_mie_d  = mstat_mie_q;
      mstat_mpie_d = mstat_mpie_q;
      mie_en_d     = mie_en_q;
      mtvec_base_d = mtvec_base_q;
      mtvec_mode_d = mtvec_mode_q;
      mepc_d       = mepc_q;
      mcause_d     = mcause_q;
      if (take_c) begin
         mepc_d       = pc[31:2];
         mcause_d     = {1'b1, 26'd0, cause_c};
         mstat_mpie_d = mstat_mie_q;
         mstat_mie_d  = 1'b0;
      end else if (mret_c) begin
         mstat_mie_d  = mstat_mpie_q;
         mstat_mpie_d = 1'b1;
      end else if (wr_c) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mstat_mie_d  = new_c[MIE_BIT];
               mstat_mpie_d = new_c[MPIE_BIT];
            end
            CSR_MIE:    mie_en_d = new_c[LOCAL_IRQ_BASE +: NUM_IRQ];
            CSR_MTVEC: begin
               mtvec_base_d = new_c[31:2];
               mtvec_mode_d = mtvec_mode_t'(new_c[0]);
            end
            CSR_MEPC:   mepc_d   = new_c[31:2];
            CSR_MCAUSE: mcause_d = new_c;
            default:    ;
         endcase
      end
   end

   // Edge pending latches; a new edge wins over any same-cycle clear
   always_comb begin
      logic clr;
      clr    = 1'b0;
      pend_d = pend_q;
      for (int i = 0; i < NUM_IRQ; i++) begin
         clr = (take_c && (id_c == ID_W'(i))) ||
               (wr_c && (csr_addr == CSR_MIP) && !new_c[LOCAL_IRQ_BASE + i]);
         pend_d[i] = EDGE_MASK[i] & (rise_c[i] | (pend_q[i] & ~clr));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstat_mie_q  <= 1'b0;
         mstat_mpie_q <= 1'b0;
         mie_en_q     <= '0;
         mtvec_base_q <= '0;
         mtvec_mode_q <= MTVEC_DIRECT;
         mepc_q       <= '0;
         mcause_q     <= '0;
         pend_q       <= '0;
      end else begin
         mstat_mie_q  <= mstat_mie_d;
         mstat_mpie_q <= mstat_mpie_d;
         mie_en_q     <= mie_en_d;
         mtvec_base_q <= mtvec_base_d;
         mtvec_mode_q <= mtvec_mode_d;
         mepc_q       <= mepc_d;
         mcause_q     <= mcause_d;
         pend_q       <= pend_d;
      end
   end

   assign csr_rd   = rd_c;
   assign mepc     = {mepc_q, 2'b00};
   assign trap_vec = {mtvec_base_q, 2'b00} +
                     ((mtvec_mode_q == MTVEC_VECTORED) ? {25'd0, cause_c, 2'b00} : 32'd0);

endmodule

// File: tb/tb_otter_intc_csr.sv
// Directed scoreboard bench for otter_intc_csr: channel 0 level, channels 1..3 rising-edge.
module tb_otter_intc_csr;
   import otter_csr_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  irq_i;
   logic [11:0] csr_addr;
   logic [31:0] csr_wd;
   logic [1:0]  csr_op;
   logic        csr_we;
   logic [31:0] pc;
   logic        int_taken;
   logic        mret_exec;
   logic [31:0] csr_rd;
   logic        int_req;
   logic [31:0] trap_vec;
   logic [31:0] mepc;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   otter_intc_csr #(
      .NUM_IRQ     (4),
      .SYNC_STAGES (2),
      .EDGE_MASK   (4'b1110)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_i     (irq_i),
      .csr_addr  (csr_addr),
      .csr_wd    (csr_wd),
      .csr_op    (csr_op),
      .csr_we    (csr_we),
      .pc        (pc),
      .int_taken (int_taken),
      .mret_exec (mret_exec),
      .csr_rd    (csr_rd),
      .int_req   (int_req),
      .trap_vec  (trap_vec),
      .mepc      (mepc)
   );

   always #50 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic compare(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: observed=%h expected=<entry>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] val);
      expect_val(tag, val);
      csr_addr = addr;
      #1;
      compare(csr_rd);
   endtask

   task automatic sig_chk(input string tag, input logic [31:0] obs, input logic [31:0] val);
      expect_val(tag, val);
      compare(obs);
   endtask

   task automatic csr_write(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
      csr_addr = addr;
      csr_op   = op;
      csr_wd   = wd;
      csr_we   = 1'b1;
      step();
      csr_we   = 1'b0;
      csr_op   = 2'b00;
   endtask

   task automatic take();
      int_taken = 1'b1;
      step();
      int_taken = 1'b0;
   endtask

   task automatic mret();
      mret_exec = 1'b1;
      step();
      mret_exec = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; irq_i = '0; csr_addr = '0; csr_wd = '0; csr_op = 2'b00;
      csr_we = 1'b0; pc = '0; int_taken = 1'b0; mret_exec = 1'b0;
      step(2);
      sig_chk("rst_int_req", 32'(int_req), 32'd0);
      sig_chk("rst_trap_vec", trap_vec, 32'd0);
      rd_chk("rst_mstatus", CSR_MSTATUS, 32'd0);
      rst_n = 1'b1;
      step();

      // enable channel 2 and take it
      csr_write(CSR_MIE, 2'b01, 32'h0004_0000);
      rd_chk("mie_en2", CSR_MIE, 32'h0004_0000);
      csr_write(CSR_MSTATUS, 2'b10, 32'h0000_0008);
      rd_chk("mstatus_mie", CSR_MSTATUS, 32'h0000_0008);
      pc = 32'h0000_0102;
      irq_i = 4'b0100;
      step(2);
      sig_chk("edge_lat_2", 32'(int_req), 32'd0);
      irq_i = 4'b0000;
      step(1);
      sig_chk("edge_lat_3", 32'(int_req), 32'd1);
      rd_chk("mip_ch2", CSR_MIP, 32'h0004_0000);
      sig_chk("trap_direct", trap_vec, 32'd0);
      take();
      sig_chk("take_req_drop", 32'(int_req), 32'd0);
      sig_chk("mepc_port", mepc, 32'h0000_0100);
      rd_chk("mepc_csr", CSR_MEPC, 32'h0000_0100);
      rd_chk("mcause_ch2", CSR_MCAUSE, 32'h8000_0012);
      rd_chk("mstatus_take", CSR_MSTATUS, 32'h0000_0080);
      rd_chk("mip_cleared", CSR_MIP, 32'h0000_0000);
      mret();
      rd_chk("mstatus_mret", CSR_MSTATUS, 32'h0000_0088);

      // vectored mode with two pending channels
      csr_write(CSR_MTVEC, 2'b01, 32'h0000_0203);
      rd_chk("mtvec_rd", CSR_MTVEC, 32'h0000_0201);
      csr_write(CSR_MIE, 2'b01, 32'h000A_0000);
      irq_i = 4'b1010;
      step(2);
      irq_i = 4'b0000;
      step(1);
      sig_chk("prio_req", 32'(int_req), 32'd1);
      sig_chk("trap_vec_17", trap_vec, 32'h0000_0244);
      rd_chk("mip_1_3", CSR_MIP, 32'h000A_0000);
      take();
      rd_chk("mcause_ch1", CSR_MCAUSE, 32'h8000_0011);
      rd_chk("mip_3_left", CSR_MIP, 32'h0008_0000);
      sig_chk("req_mie_off", 32'(int_req), 32'd0);
      csr_write(CSR_MSTATUS, 2'b10, 32'h0000_0008);
      sig_chk("req_mie_on", 32'(int_req), 32'd1);
      sig_chk("trap_vec_19", trap_vec, 32'h0000_024C);

      // trap beats mret beats write
      int_taken = 1'b1; mret_exec = 1'b1;
      csr_addr = CSR_MIE; csr_op = 2'b01; csr_wd = 32'd0; csr_we = 1'b1;
      step();
      int_taken = 1'b0; mret_exec = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
      rd_chk("race_mstatus", CSR_MSTATUS, 32'h0000_0080);
      rd_chk("race_mcause", CSR_MCAUSE, 32'h8000_0013);
      rd_chk("race_mie_kept", CSR_MIE, 32'h000A_0000);
      rd_chk("race_mip", CSR_MIP, 32'h0000_0000);
      mret();
      rd_chk("mret2_mstatus", CSR_MSTATUS, 32'h0000_0088);

      // RW / RS / RC on mie, then mip write semantics
      csr_write(CSR_MIE, 2'b01, 32'h0003_0000);
      rd_chk("mie_rw", CSR_MIE, 32'h0003_0000);
      csr_write(CSR_MIE, 2'b10, 32'h0004_0000);
      rd_chk("mie_rs", CSR_MIE, 32'h0007_0000);
      csr_write(CSR_MIE, 2'b11, 32'h0001_0000);
      rd_chk("mie_rc", CSR_MIE, 32'h0006_0000);
      irq_i = 4'b0010;
      step(2);
      irq_i = 4'b0000;
      step(1);
      rd_chk("mip_ch1", CSR_MIP, 32'h0002_0000);
      csr_write(CSR_MIP, 2'b10, 32'h0008_0000);
      rd_chk("mip_rs_ign", CSR_MIP, 32'h0002_0000);
      csr_write(CSR_MIP, 2'b11, 32'h0002_0000);
      rd_chk("mip_rc_clr", CSR_MIP, 32'h0000_0000);

      // level channel 0
      csr_write(CSR_MIE, 2'b01, 32'h0001_0000);
      irq_i = 4'b0001;
      step(1);
      sig_chk("lvl_lat_1", 32'(int_req), 32'd0);
      step(1);
      sig_chk("lvl_lat_2", 32'(int_req), 32'd1);
      take();
      rd_chk("lvl_mcause", CSR_MCAUSE, 32'h8000_0010);
      sig_chk("lvl_req_off", 32'(int_req), 32'd0);
      rd_chk("lvl_pend_kept", CSR_MIP, 32'h0001_0000);
      csr_write(CSR_MIP, 2'b11, 32'h0001_0000);
      rd_chk("lvl_rc_ign", CSR_MIP, 32'h0001_0000);
      mret();
      sig_chk("lvl_req_back", 32'(int_req), 32'd1);

      // edge on the same cycle as its own clear
      irq_i = 4'b0101;
      step(2);
      csr_write(CSR_MIP, 2'b11, 32'h0004_0000);
      irq_i = 4'b0001;
      rd_chk("set_beats_clr", CSR_MIP, 32'h0005_0000);
      csr_write(CSR_MIP, 2'b11, 32'h0004_0000);
      rd_chk("clr_after", CSR_MIP, 32'h0001_0000);

      // asynchronous reset mid-run
      sig_chk("pre_rst_req", 32'(int_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      sig_chk("arst_int_req", 32'(int_req), 32'd0);
      sig_chk("arst_trap_vec", trap_vec, 32'd0);
      sig_chk("arst_mepc", mepc, 32'd0);
      rd_chk("arst_mstatus", CSR_MSTATUS, 32'd0);
      rd_chk("arst_mie", CSR_MIE, 32'd0);
      rd_chk("arst_mtvec", CSR_MTVEC, 32'd0);
      rd_chk("arst_mcause", CSR_MCAUSE, 32'd0);
      rd_chk("arst_mip", CSR_MIP, 32'd0);
      irq_i = 4'b0000;
      rst_n = 1'b1;
      step(2);

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
